tone_mix_pwm: RTL and testbench
===============================

Name: tone_mix_pwm

Overview:
- Downstream consumer of the tone_generator_2 square-wave outputs.
- Takes NCH asynchronous SOUT tone bits, synchronises each to CLK and weights it by a 4-bit per-channel volume register.
- Sums the weighted channels into a level and drives a single-bit first-order PWM DAC output to the pad.
- Volume registers use the same nibble-write style as the tone period registers: DIN plus one-hot select strobes.

Parameters:
- NCH, 3: number of tone channels mixed (1..4).
- PWM_BITS, 6: PWM counter width. PWM period = 2^PWM_BITS CLK cycles.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_C  in  1  reset, synchronous, active-low.
- DIN  in  4  volume write data (0 = silent, 15 = loudest).
- VSEL  in  NCH  one-hot-per-channel volume write strobes.
- NSEL  in  1  noise volume write strobe; ignored unless TONE_MIX_NOISE_EN.
- MUTE  in  1  forces the latched level to 0.
- TONE_IN  in  NCH  SOUT of each tone_generator_2; asynchronous to CLK.
- PWM_OUT  out  1  registered PWM output.
- LEVEL  out  PWM_BITS  level latched for the current PWM frame.
- FRAME  out  1  one-cycle pulse on the last cycle of each frame.

Behaviour:
- Reset (RST_C=0 at a CLK edge) clears:
  - every volume register, the sync flops, the PWM counter (cnt), LEVEL, PWM_OUT and FRAME, all to 0;
  - the noise LFSR (if present), which is set to 15'h4000.
- Reset asserted mid-frame aborts the frame. First frame after release starts at cnt=0 with LEVEL=0.
- Synchroniser:
  - two-flop sync per TONE_IN bit, giving ts[i];
  - a change on TONE_IN is visible in ts after 2–3 CLK edges.
- Volume write:
  - when VSEL[i]=1 at a CLK edge, vol[i] <= DIN;
  - several VSEL bits high load the same DIN into every selected channel;
  - VSEL=0 holds all registers;
  - a write and a reset in the same cycle: reset wins.
- Mix sum: sum = Σ (ts[i] ? vol[i] : 0), computed combinationally.
  - Width is wide enough for NCH*15 (+15 with noise).
  - If sum > 2^PWM_BITS-1, it saturates to 2^PWM_BITS-1.
- Counter and frame:
  - cnt increments every CLK. When cnt == 2^PWM_BITS-1: cnt <= 0, FRAME <= 1, LEVEL <= (MUTE ? 0 : sat(sum)).
  - Otherwise FRAME <= 0 and LEVEL holds.
  - Volume writes, MUTE changes and tone edges mid-frame therefore take effect only at the next frame boundary. No glitching within a frame.
- PWM output: PWM_OUT <= (cnt < LEVEL), registered.
  - PWM_OUT is high for exactly LEVEL cycles per frame, delayed 1 CLK relative to cnt.
  - LEVEL=0 gives constant 0. LEVEL = max gives high for 2^PWM_BITS-1 of 2^PWM_BITS cycles.
- Synthesis-time check: NCH outside 1..4 is a fatal error.

Optional Feature:
- Macro: TONE_MIX_NOISE_EN.
- Defined:
  - adds a 15-bit Fibonacci LFSR with taps 15,14 (x^15+x^14+1), shifting once on each rising edge of ts[NCH-1];
  - noise bit = LFSR[0];
  - adds a 4-bit nvol register, written from DIN when NSEL=1;
  - sum gains the term (LFSR[0] ? nvol : 0);
  - LFSR resets to 15'h4000 and never reaches all-zero.
- Undefined:
  - no LFSR, no nvol;
  - NSEL has no effect; sum contains tone terms only;
  - port list is unchanged.

Test Plan:
- Reset then idle: RST_C=0 for 2 cycles, TONE_IN=3'b111 -> LEVEL=0, PWM_OUT=0 for the whole frame; FRAME pulses every 64 cycles.
- Volume write: DIN=9, VSEL=3'b001, TONE_IN=3'b001 held -> after the next FRAME, LEVEL=9; PWM_OUT high exactly 9 of 64 cycles.
- Mixing: vol={15,15,15}, TONE_IN=3'b111 -> LEVEL=45. TONE_IN=3'b101 -> LEVEL=30 from the frame after sync.
- Mid-frame change: write vol[0]=4 at cnt=20 while LEVEL=9 -> remainder of the frame still high for 9 cycles total; next frame LEVEL=4.
- MUTE and saturation:
  - MUTE=1 -> LEVEL=0 at the next boundary;
  - with PWM_BITS=5 and vol={15,15,15} all on -> LEVEL=31, PWM_OUT high 31 of 32.
- Noise (TONE_MIX_NOISE_EN): nvol=15, toggle TONE_IN[2] -> LFSR steps 4000,2000,1000… per rising edge; LEVEL includes +15 whenever LFSR[0]=1; NSEL ignored when the macro is undefined.

Source files
------------

// File: rtl/tone_mix_pwm.sv
// Mixes NCH synchronised tone bits, each weighted by a 4-bit volume, into a per-frame PWM level.
// Define TONE_MIX_NOISE_EN to add an LFSR noise channel with its own volume (nvol, written via NSEL).
module tone_mix_pwm #(
  parameter int NCH      = 3,
  parameter int PWM_BITS = 6
) (
  input  logic                CLK,
  input  logic                RST_C,
  input  logic [3:0]          DIN,
  input  logic [NCH-1:0]      VSEL,
  input  logic                NSEL,
  input  logic                MUTE,
  input  logic [NCH-1:0]      TONE_IN,
  output logic                PWM_OUT,
  output logic [PWM_BITS-1:0] LEVEL,
  output logic                FRAME
);

  localparam int SUM_W = (PWM_BITS > 7) ? PWM_BITS : 7;
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
  localparam logic [SUM_W-1:0]    SAT_MAX = SUM_W'(CNT_MAX);

  if (NCH < 1 || NCH > 4) begin : g_bad_nch
    $fatal(1, "tone_mix_pwm: NCH must be in 1..4");
  end

  logic [NCH-1:0]      ts_meta_q, ts_q;
  logic [3:0]          vol_q [NCH];
  logic [3:0]          vol_d [NCH];
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic                pwm_q, pwm_d;
  logic                frame_q, frame_d;
  logic [3:0]          noise_term;
  logic [SUM_W-1:0]    sum;
  logic [PWM_BITS-1:0] sat_lvl;

  always_ff @(posedge CLK) begin
    if (!RST_C) begin
      ts_meta_q <= '0;
      ts_q      <= '0;
    end else begin
      ts_meta_q <= TONE_IN;
      ts_q      <= ts_meta_q;
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      vol_d[i] = VSEL[i] ? DIN : vol_q[i];
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NCH; i++) begin
      if (!RST_C) vol_q[i] <= '0;
      else        vol_q[i] <= vol_d[i];
    end
  end

`ifdef TONE_MIX_NOISE_EN
  logic [14:0] lfsr_q, lfsr_d;
  logic [3:0]  nvol_q, nvol_d;
  logic        ts_last_q;

  // Right-shifting form of x^15+x^14+1: output bit 0, feedback into bit 14.
  always_comb begin
    lfsr_d = lfsr_q;
    if (ts_q[NCH-1] && !ts_last_q) begin
      lfsr_d = {lfsr_q[1] ^ lfsr_q[0], lfsr_q[14:1]};
    end
    nvol_d = NSEL ? DIN : nvol_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_C) begin
      lfsr_q    <= 15'h4000;
      nvol_q    <= '0;
      ts_last_q <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_d;
      nvol_q    <= nvol_d;
      ts_last_q <= ts_q[NCH-1];
    end
  end

  assign noise_term = lfsr_q[0] ? nvol_q : 4'd0;
`else
  logic unused_nsel;
  assign unused_nsel = NSEL;
  assign noise_term  = 4'd0;
`endif

  always_comb begin
    sum = SUM_W'(noise_term);
    for (int i = 0; i < NCH; i++) begin
      if (ts_q[i]) sum = sum + SUM_W'(vol_q[i]);
    end
    sat_lvl = (sum > SAT_MAX) ? CNT_MAX : sum[PWM_BITS-1:0];
  end

  // Level is only sampled at the frame boundary so a frame never glitches.
  always_comb begin
    cnt_d   = cnt_q + PWM_BITS'(1);
    frame_d = 1'b0;
    level_d = level_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      frame_d = 1'b1;
      level_d = MUTE ? '0 : sat_lvl;
    end
    pwm_d = (cnt_q < level_q);
  end

  always_ff @(posedge CLK) begin
    if (!RST_C) begin
      cnt_q   <= '0;
      level_q <= '0;
      pwm_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pwm_q   <= pwm_d;
      frame_q <= frame_d;
    end
  end

  assign PWM_OUT = pwm_q;
  assign LEVEL   = level_q;
  assign FRAME   = frame_q;

endmodule

// File: tb/tb_tone_mix_pwm.sv
// Randomised bench for tone_mix_pwm: two instances (6-bit and 5-bit PWM) against a frame-level model.
module tb_tone_mix_pwm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] din;
  logic [2:0] vsel;
  logic       nsel;
  logic       mute;
  logic [2:0] tone;
  logic       pwm6, frm6, pwm5, frm5;
  logic [5:0] lvl6;
  logic [4:0] lvl5;

  always #5 clk = ~clk;

  tone_mix_pwm #(.NCH(3), .PWM_BITS(6)) u_dut (
    .CLK(clk), .RST_C(rst_n), .DIN(din), .VSEL(vsel), .NSEL(nsel), .MUTE(mute),
    .TONE_IN(tone), .PWM_OUT(pwm6), .LEVEL(lvl6), .FRAME(frm6));

  tone_mix_pwm #(.NCH(3), .PWM_BITS(5)) u_dut5 (
    .CLK(clk), .RST_C(rst_n), .DIN(din), .VSEL(vsel), .NSEL(nsel), .MUTE(mute),
    .TONE_IN(tone), .PWM_OUT(pwm5), .LEVEL(lvl5), .FRAME(frm5));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
  endtask

  // Reference model: index 0 = 64-cycle frame, index 1 = 32-cycle frame.
  int         m_cnt [2];
  int         m_lvl [2];
  int         m_pwm [2];
  int         m_frm [2];
  int         m_vol [3];
  logic [2:0] h1, h2, h3;   // TONE_IN seen 1, 2, 3 edges ago
  int         s, mx;
  bit         armed = 1'b0;
`ifdef TONE_MIX_NOISE_EN
  int          m_nvol;
  logic [14:0] m_lfsr;
`endif

  always @(posedge clk) begin
    if (!rst_n) begin
      armed = 1'b1;
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0; m_lvl[k] = 0; m_pwm[k] = 0; m_frm[k] = 0;
      end
      for (int i = 0; i < 3; i++) m_vol[i] = 0;
      h1 = '0; h2 = '0; h3 = '0;
`ifdef TONE_MIX_NOISE_EN
      m_nvol = 0; m_lfsr = 15'h4000;
`endif
    end else begin
      s = 0;
      for (int i = 0; i < 3; i++) if (h2[i]) s += m_vol[i];
`ifdef TONE_MIX_NOISE_EN
      if (m_lfsr[0]) s += m_nvol;
      if (h2[2] && !h3[2]) m_lfsr = {m_lfsr[0] ^ m_lfsr[1], m_lfsr[14:1]};
      if (nsel) m_nvol = int'(din);
`endif
      for (int k = 0; k < 2; k++) begin
        mx = (k == 0) ? 63 : 31;
        m_pwm[k] = (m_cnt[k] < m_lvl[k]) ? 1 : 0;
        if (m_cnt[k] == mx) begin
          m_cnt[k] = 0;
          m_frm[k] = 1;
          m_lvl[k] = mute ? 0 : ((s > mx) ? mx : s);
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
          m_frm[k] = 0;
        end
      end
      for (int i = 0; i < 3; i++) if (vsel[i]) m_vol[i] = int'(din);
      h3 = h2; h2 = h1; h1 = tone;
    end
  end

  // Per-cycle compare plus a per-frame duty check (high cycles must equal the latched level).
  int hi_f [2];
  int lvl_f [2];
  bit fvalid [2];

  always @(negedge clk) begin
    if (armed) begin
      chk("level6", int'(lvl6), m_lvl[0]);
      chk("frame6", int'(frm6), m_frm[0]);
      chk("pwm6",   int'(pwm6), m_pwm[0]);
      chk("level5", int'(lvl5), m_lvl[1]);
      chk("frame5", int'(frm5), m_frm[1]);
      chk("pwm5",   int'(pwm5), m_pwm[1]);
    end
    if (!rst_n) begin
      fvalid[0] = 0; fvalid[1] = 0; hi_f[0] = 0; hi_f[1] = 0;
    end else begin
      hi_f[0] += int'(pwm6);
      hi_f[1] += int'(pwm5);
      if (frm6) begin
        if (fvalid[0]) chk("duty6", hi_f[0], lvl_f[0]);
        lvl_f[0] = int'(lvl6); hi_f[0] = 0; fvalid[0] = 1;
      end
      if (frm5) begin
        if (fvalid[1]) chk("duty5", hi_f[1], lvl_f[1]);
        lvl_f[1] = int'(lvl5); hi_f[1] = 0; fvalid[1] = 1;
      end
    end
  end

  task automatic wait_frame(output int cyc);
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cyc++;
      if (frm6) return;
    end
    chk("frame_timeout", 0, 1);
  endtask

  int c, hi;

  initial begin
    rst_n = 1'b0; din = '0; vsel = '0; nsel = 1'b0; mute = 1'b0; tone = 3'b111;
    repeat (2) @(negedge clk);
    chk("rst_level", int'(lvl6), 0);
    chk("rst_pwm",   int'(pwm6), 0);
    chk("rst_frame", int'(frm6), 0);
    rst_n = 1'b1;
    wait_frame(c);
    wait_frame(c);
    chk("frame_period", c, 64);
    chk("idle_level", int'(lvl6), 0);

    tone = 3'b001; din = 4'd9; vsel = 3'b001;
    @(negedge clk); vsel = '0;
    wait_frame(c); wait_frame(c);
    chk("vol_level", int'(lvl6), 9);

    hi = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      hi += int'(pwm6);
      if (i == 20) begin din = 4'd4; vsel = 3'b001; end
      if (i == 21) vsel = '0;
    end
    chk("mid_hi", hi, 9);
    chk("mid_frame", int'(frm6), 1);
    chk("mid_level", int'(lvl6), 4);

    tone = 3'b111; din = 4'd15; vsel = 3'b111;
    @(negedge clk); vsel = '0;
    wait_frame(c); wait_frame(c);
    chk("mix_level", int'(lvl6), 45);
    chk("sat_level", int'(lvl5), 31);
    c = 0;
    while (!frm5 && c < 100) begin @(negedge clk); c++; end
    hi = 0;
    for (int i = 0; i < 32; i++) begin @(negedge clk); hi += int'(pwm5); end
    chk("sat_hi", hi, 31);

    tone = 3'b101;
    wait_frame(c); wait_frame(c);
    chk("mix101_level", int'(lvl6), 30);
    chk("mix101_level5", int'(lvl5), 30);

    mute = 1'b1;
    wait_frame(c);
    chk("mute_level", int'(lvl6), 0);
    mute = 1'b0;
    wait_frame(c);
    chk("unmute_level", int'(lvl6), 30);

`ifndef TONE_MIX_NOISE_EN
    nsel = 1'b1; din = 4'd15;
    @(negedge clk); nsel = 1'b0;
    wait_frame(c); wait_frame(c);
    chk("nsel_ignored", int'(lvl6), 30);
`endif

    wait_frame(c);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_level", int'(lvl6), 0);
    chk("midrst_pwm", int'(pwm6), 0);
    wait_frame(c);
    chk("midrst_period", c, 64);

    repeat (4000) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) tone = 3'($urandom);
      vsel  = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b000;
      din   = 4'($urandom);
      nsel  = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 255) == 0) mute = ~mute;
      rst_n = ($urandom_range(0, 1499) != 0);
    end
    rst_n = 1'b1;
    repeat (130) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
